// File: rtl/msl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msl_pkg
//  Purpose  : Shared definitions for the MSL single-wire link: line timing in
//             units of T, receiver threshold multipliers, FSM state encoding
//             and the segment classifier used by the receiver.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package msl_pkg;

  // Line timing as driven by the sender, in units of T
  localparam int START_LO_T = 5;
  localparam int START_HI_T = 5;
  localparam int BIT0_T     = 5;
  localparam int BIT1_T     = 10;
  localparam int STOP_LO_T  = 5;
  localparam int GAP_T      = 25;

  // Receiver thresholds in units of T; the 7.5T split is kept in half-T
  localparam int C_MIN_MULT   = 3;
  localparam int C_SPLIT_X2   = 15;
  localparam int C_MAX_MULT   = 13;
  localparam int C_IDLE_MULT  = 20;

  // State encoding, common to sender and receiver
  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_START_LO  = 3'd2;
  localparam logic [2:0] ST_START_HI  = 3'd3;
  localparam logic [2:0] ST_DATA      = 3'd4;
  localparam logic [2:0] ST_STOP_LO   = 3'd5;
  localparam logic [2:0] ST_STOP_HI   = 3'd6;

  typedef enum logic [2:0] {
    S_WAIT_IDLE = ST_WAIT_IDLE,
    S_IDLE      = ST_IDLE,
    S_START_LO  = ST_START_LO,
    S_START_HI  = ST_START_HI,
    S_DATA      = ST_DATA,
    S_STOP_LO   = ST_STOP_LO,
    S_STOP_HI   = ST_STOP_HI
  } msl_state_e;

  typedef enum logic [1:0] {
    SEG_ERR   = 2'd0,
    SEG_SHORT = 2'd1,
    SEG_LONG  = 2'd2
  } msl_seg_e;

  // Classify a segment length (cycles since the previous edge)
  function automatic msl_seg_e msl_classify(
    input logic [31:0] len,
    input logic [31:0] c_min,
    input logic [31:0] c_split,
    input logic [31:0] c_max
  );
    msl_seg_e seg;
    seg = SEG_ERR;
    if ((len >= c_min) && (len < c_split)) begin
      seg = SEG_SHORT;
    end else if ((len >= c_split) && (len <= c_max)) begin
      seg = SEG_LONG;
    end
    return seg;
  endfunction

endpackage : msl_pkg
`default_nettype wire

// File: rtl/msl_rx_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : msl_rx_sync_edge
//  Purpose  : Two-flop synchroniser for the asynchronous MSL line followed by
//             a registered level and registered rise/fall pulses. The pulses
//             and o_level are mutually aligned, three cycles after the pin.
//  Ports    : i_clk    - clock, rising edge
//             i_rst_n  - asynchronous active-low reset
//             i_d      - raw asynchronous line
//             o_level  - synchronised level, aligned with o_rise/o_fall
//             o_rise   - 1-cycle pulse on a low-to-high transition
//             o_fall   - 1-cycle pulse on a high-to-low transition
//  Revision : 1.0 - initial release
// ============================================================================
module msl_rx_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_lvl;
  logic r_rise;
  logic r_fall;

  // Reset to the idle-high level so release never fabricates an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_lvl  <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_lvl  <= r_s2;
      r_rise <= r_s2 & ~r_lvl;
      r_fall <= ~r_s2 & r_lvl;
    end
  end

  assign o_level = r_lvl;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : msl_rx_sync_edge
`default_nettype wire

// File: rtl/msl_slave_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : msl_slave_receiver
//  Purpose  : Decodes the MSL pulse-width single-wire line into parallel
//             words. Emits o_valid once per clean frame, o_frame_err once per
//             aborted frame. Optional error counter under MSL_RX_ERR_CNT_EN.
//  Ports    : i_clk       - clock, rising edge
//             i_rst_n     - asynchronous active-low reset
//             i_msl_sda   - MSL line, asynchronous
//             o_data      - last good word, held until the next good frame
//             o_valid     - 1-cycle pulse when o_data updates
//             o_frame_err - 1-cycle pulse when a frame is aborted
//             o_busy      - high while a frame is being received
//             o_err_cnt   - saturating error count (MSL_RX_ERR_CNT_EN only)
//  Revision : 1.0 - initial release
// ============================================================================
module msl_slave_receiver
  import msl_pkg::*;
#(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_SYSTEM_CLK  = 50_000_000,
  parameter int P_TICK_CYCLES = P_SYSTEM_CLK / 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_msl_sda,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  output logic                    o_frame_err,
  output logic                    o_busy
`ifdef MSL_RX_ERR_CNT_EN
  ,
  output logic [7:0]              o_err_cnt
`endif
);

  localparam logic [31:0] C_MIN   = 32'(C_MIN_MULT * P_TICK_CYCLES);
  localparam logic [31:0] C_SPLIT = 32'((C_SPLIT_X2 * P_TICK_CYCLES) / 2);
  localparam logic [31:0] C_MAX   = 32'(C_MAX_MULT * P_TICK_CYCLES);
  localparam logic [31:0] C_IDLE  = 32'(C_IDLE_MULT * P_TICK_CYCLES);
  localparam int          IDX_W   = $clog2(P_DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(P_DATA_WIDTH);

  logic                    w_level;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_edge;
  msl_seg_e                w_seg;
  logic                    w_timeout;

  msl_state_e              r_state;
  msl_state_e              w_state_nxt;
  logic [31:0]             r_len;
  logic [P_DATA_WIDTH-1:0] r_shift;
  logic [P_DATA_WIDTH-1:0] w_shift_nxt;
  logic [IDX_W-1:0]        r_bit_idx;
  logic [IDX_W-1:0]        w_bit_idx_nxt;
  logic                    w_commit;
  logic                    w_err;

  msl_rx_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_msl_sda),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_edge    = w_rise | w_fall;
  assign w_seg     = msl_classify(r_len, C_MIN, C_SPLIT, C_MAX);
  assign w_timeout = (r_len > C_MAX);

  // Cycles since the last edge. While waiting for idle, a low line keeps it
  // at zero so only an unbroken C_IDLE of high releases the FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len <= 32'd0;
    end else if (w_edge || ((r_state == S_WAIT_IDLE) && !w_level)) begin
      r_len <= 32'd0;
    end else if (r_len != C_IDLE) begin
      r_len <= r_len + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_WAIT_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // An edge always takes priority over a timeout in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_commit      = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      S_WAIT_IDLE: begin
        if (w_level && (r_len == C_IDLE)) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START_LO;
      end
      S_START_LO: begin
        if (w_edge) begin
          if (w_rise && (w_seg == SEG_SHORT)) w_state_nxt = S_START_HI;
          else                                w_err       = 1'b1;
        end else if (w_timeout) begin
          w_err = 1'b1;
        end
      end
      S_START_HI: begin
        if (w_edge) begin
          if (w_fall && (w_seg == SEG_SHORT)) begin
            w_state_nxt   = S_DATA;
            w_shift_nxt   = '0;
            w_bit_idx_nxt = '0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_edge) begin
          if (w_seg == SEG_ERR) begin
            w_err = 1'b1;
          end else begin
            w_shift_nxt   = {r_shift[P_DATA_WIDTH-2:0], (w_seg == SEG_LONG)};
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            // Even word width means this final edge is always a fall
            if (w_bit_idx_nxt == C_LAST_IDX) w_state_nxt = S_STOP_LO;
          end
        end else if (w_timeout) begin
          w_err = 1'b1;
        end
      end
      S_STOP_LO: begin
        if (w_edge) begin
          if (w_rise && (w_seg == SEG_SHORT)) w_state_nxt = S_STOP_HI;
          else                                w_err       = 1'b1;
        end else if (w_timeout) begin
          w_err = 1'b1;
        end
      end
      S_STOP_HI: begin
        if (w_edge) begin
          w_err = 1'b1;
        end else if (r_len == C_IDLE) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_IDLE;
      end
    endcase
    if (w_err) w_state_nxt = S_WAIT_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= w_commit;
      o_frame_err <= w_err;
      if (w_commit) o_data <= r_shift;
    end
  end

  assign o_busy = (r_state != S_IDLE) && (r_state != S_WAIT_IDLE);

`ifdef MSL_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule : msl_slave_receiver
`default_nettype wire

// File: tb/tb_msl_slave_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msl_slave_receiver
//  Purpose  : Directed self-checking bench for msl_slave_receiver with
//             T = 10 cycles. A behavioural sender drives the line; a monitor
//             counts o_valid / o_frame_err pulses. Set MSL_RX_ERR_CNT_EN to
//             exercise the saturating error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msl_slave_receiver;

  localparam int T = 10;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_msl_sda;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
`ifdef MSL_RX_ERR_CNT_EN
  logic [7:0] o_err_cnt;
`endif

  int checks    = 0;
  int failures  = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int exp_valid = 0;
  int exp_err   = 0;

  msl_slave_receiver #(
    .P_DATA_WIDTH  (8),
    .P_SYSTEM_CLK  (10_000),
    .P_TICK_CYCLES (T)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_msl_sda   (i_msl_sda),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
`ifdef MSL_RX_ERR_CNT_EN
    ,
    .o_err_cnt   (o_err_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse monitor, sampled 1 time unit after each rising edge
  always @(posedge i_clk) begin
    #1;
    if (o_valid === 1'b1)     valid_cnt++;
    if (o_frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the line at a level for n cycles (driven on falling edges)
  task automatic seg(input logic lvl, input int n);
    i_msl_sda = lvl;
    repeat (n) @(negedge i_clk);
  endtask

  // Full frame; rst_seg selects a data segment during which reset is pulsed
  task automatic send_frame(input logic [7:0] d, input int gap_t, input int rst_seg);
    seg(1'b0, 5*T);
    seg(1'b1, 5*T);
    for (int k = 0; k < 8; k++) begin
      int   len;
      logic lvl;
      len = d[7-k] ? 10*T : 5*T;
      lvl = k[0];
      if (k == rst_seg) begin
        seg(lvl, 20);
        i_rst_n = 1'b0;
        seg(lvl, 3);
        chk("rst_mid_data",   32'(o_data),      32'h0);
        chk("rst_mid_valid",  32'(o_valid),     32'h0);
        chk("rst_mid_err",    32'(o_frame_err), 32'h0);
        chk("rst_mid_busy",   32'(o_busy),      32'h0);
        i_rst_n = 1'b1;
        seg(lvl, len - 23);
      end else begin
        seg(lvl, len);
      end
    end
    seg(1'b0, 5*T);
    seg(1'b1, gap_t*T);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] exp_d);
    exp_valid++;
    chk({tag, "_valid"}, 32'(valid_cnt), 32'(exp_valid));
    chk({tag, "_data"},  32'(o_data),    32'(exp_d));
    chk({tag, "_err"},   32'(err_cnt),   32'(exp_err));
  endtask

  initial begin
    i_msl_sda = 1'b1;
    i_rst_n   = 1'b0;
    repeat (5) @(negedge i_clk);
    chk("reset_data",  32'(o_data),      32'h0);
    chk("reset_valid", 32'(o_valid),     32'h0);
    chk("reset_err",   32'(o_frame_err), 32'h0);
    chk("reset_busy",  32'(o_busy),      32'h0);
`ifdef MSL_RX_ERR_CNT_EN
    chk("reset_errcnt", 32'(o_err_cnt),  32'h0);
`endif
    i_rst_n = 1'b1;
    seg(1'b1, 21*T);

    // 1: single frame, 31T gap
    send_frame(8'hA5, 31, -1);
    chk_frame("f_a5", 8'hA5);
    chk("idle_busy", 32'(o_busy), 32'h0);

    // 2: back-to-back frames with the minimum gap
    send_frame(8'h00, 25, -1);
    chk_frame("f_00", 8'h00);
    send_frame(8'hFF, 25, -1);
    chk_frame("f_ff", 8'hFF);
    send_frame(8'h3C, 25, -1);
    chk_frame("f_3c", 8'h3C);

    // 3: start low only 2T; error reported at the rise
    seg(1'b0, 2*T);
    chk("short_start_busy",    32'(o_busy),  32'h1);
    chk("short_start_pre_err", 32'(err_cnt), 32'(exp_err));
    seg(1'b1, 5);
    exp_err++;
    chk("short_start_err",     32'(err_cnt), 32'(exp_err));
    seg(1'b1, 21*T);
    chk("short_start_novalid", 32'(valid_cnt), 32'(exp_valid));
    chk("short_start_data",    32'(o_data),    32'h3C);
    send_frame(8'h5A, 31, -1);
    chk_frame("f_5a", 8'h5A);

    // 4: line stuck low 15T inside the data field; timeout at r_len=131
    seg(1'b0, 5*T);
    seg(1'b1, 5*T);
    seg(1'b0, 5*T);
    seg(1'b1, 10*T);
    seg(1'b0, 125);
    chk("stuck_low_pre_err", 32'(err_cnt), 32'(exp_err));
    seg(1'b0, 25);
    exp_err++;
    chk("stuck_low_err",     32'(err_cnt), 32'(exp_err));
    seg(1'b1, 25*T);
    chk("stuck_low_novalid", 32'(valid_cnt), 32'(exp_valid));
    send_frame(8'hC3, 31, -1);
    chk_frame("f_c3", 8'hC3);

    // 5: reset during bit 4 of 0x81 drops that frame silently
    send_frame(8'h81, 31, 3);
    chk("rst_drop_valid", 32'(valid_cnt), 32'(exp_valid));
    chk("rst_drop_err",   32'(err_cnt),   32'(exp_err));
    chk("rst_drop_data",  32'(o_data),    32'h0);
    send_frame(8'h81, 31, -1);
    chk_frame("f_81", 8'h81);

`ifdef MSL_RX_ERR_CNT_EN
    // 6: 300 bad frames saturate the error counter at 255
    chk("errcnt_after_rst", 32'(o_err_cnt), 32'h0);
    for (int n = 0; n < 300; n++) begin
      seg(1'b0, 2*T);
      seg(1'b1, 21*T);
      exp_err++;
      if (n == 99) chk("errcnt_100", 32'(o_err_cnt), 32'd100);
    end
    chk("errcnt_sat",   32'(o_err_cnt), 32'd255);
    chk("errcnt_pulses", 32'(err_cnt),  32'(exp_err));
    send_frame(8'h96, 31, -1);
    chk_frame("f_96", 8'h96);
    chk("errcnt_hold",  32'(o_err_cnt), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_msl_slave_receiver
`default_nettype wire
